// File: rtl/clock_pkg.sv
// clock_pkg
// Shared definitions for the clock time core and the seven-segment display
// driver that consumes its digits.
//   bcd_t / bcd_pair_t : one BCD digit, and a tens/ones digit pair
//   *_MAX / *_MIN      : legal ranges of the seconds, minutes and hours fields
//   SCAN_*             : refresh_digit encodings used to pick the displayed digit
//   to_bcd_pair        : converts a small integer constant into a BCD pair
//   bcd_pair_inc       : BCD +1 on a pair; the caller handles the field wrap
package clock_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t ones;
  } bcd_pair_t;

  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t MIN_TENS_MAX = 4'd5;
  localparam int   HR24_MAX     = 23;
  localparam int   HR12_MIN     = 1;
  localparam int   HR12_MAX     = 12;

  localparam logic [1:0] SCAN_MIN_1S  = 2'd0;
  localparam logic [1:0] SCAN_MIN_10S = 2'd1;
  localparam logic [1:0] SCAN_HR_1S   = 2'd2;
  localparam logic [1:0] SCAN_HR_10S  = 2'd3;

  function automatic bcd_pair_t to_bcd_pair(input int value);
    bcd_pair_t r;
    r.tens = bcd_t'(value / 10);
    r.ones = bcd_t'(value % 10);
    return r;
  endfunction

  // The tens digit only moves when the ones digit rolls 9 -> 0.
  function automatic bcd_pair_t bcd_pair_inc(input bcd_pair_t v);
    bcd_pair_t r;
    r = v;
    if (v.ones == 4'd9) begin
      r.ones = 4'd0;
      r.tens = v.tens + 4'd1;
    end else begin
      r.ones = v.ones + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// button_debounce
// Turns a raw, bouncing, asynchronous push button into a single-cycle press
// pulse: 2-FF synchroniser, stable-level filter, rising-edge detector.
// Parameter:
//   DEBOUNCE_CYCLES : consecutive equal samples needed to accept a new level
// Ports:
//   clk     : rising-edge clock
//   reset_n : synchronous active-low reset, returns the filter to "released"
//   btn     : raw active-high button input
//   press   : registered one-cycle pulse on each accepted press
module button_debounce
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_a;
  logic             sync_b;
  logic             level;
  logic             level_d;
  logic [CNT_W-1:0] cnt;
  logic             press_q;

  // cnt counts consecutive synchronised samples that disagree with the
  // accepted level; any agreeing sample restarts the count, so a bouncing
  // contact never gets through. The edge detector runs one stage behind the
  // accepted level so the pulse is registered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_a  <= 1'b0;
      sync_b  <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
      press_q <= 1'b0;
    end else begin
      sync_a  <= btn;
      sync_b  <= sync_a;
      level_d <= level;
      press_q <= level & ~level_d;
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_b;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign press = press_q;

endmodule

// File: rtl/clock_time_core.sv
// clock_time_core
// Time-keeping source for the digital clock: divides clk down to a 1 Hz
// advance, keeps hh:mm:ss as BCD digits, applies debounced hour/minute set
// buttons and produces the display scan select.
// Build option: define CLOCK_12H_MODE_EN for a 01..12 hour display with a PM
// flag; otherwise hours run 00..23 and pm is constant 0.
// Parameters: CLK_HZ (prescaler period), DEBOUNCE_CYCLES, REFRESH_BITS.
// Ports:
//   clk, reset_n          : rising-edge clock, synchronous active-low reset
//   run_en                : 1 lets the prescaler count, 0 freezes it
//   btn_hr, btn_min       : raw active-high set buttons
//   sec_*, min_*, hr_*    : BCD time digits (registered)
//   pm                    : PM flag (12 h build only)
//   tick_1hz              : one-cycle pulse in the first cycle of a new second
//   refresh_digit         : top two bits of the free-running refresh counter
module clock_time_core
  import clock_pkg::*;
#(
  parameter int CLK_HZ          = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REFRESH_BITS    = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       run_en,
  input  logic       btn_hr,
  input  logic       btn_min,
  output logic [3:0] sec_1s,
  output logic [3:0] sec_10s,
  output logic [3:0] min_1s,
  output logic [3:0] min_10s,
  output logic [3:0] hr_1s,
  output logic [3:0] hr_10s,
  output logic       pm,
  output logic       tick_1hz,
  output logic [1:0] refresh_digit
);

  localparam int PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);
  localparam bcd_pair_t SEC_MAX_BCD = {SEC_TENS_MAX, 4'd9};
  localparam bcd_pair_t MIN_MAX_BCD = {MIN_TENS_MAX, 4'd9};

`ifdef CLOCK_12H_MODE_EN
  localparam bcd_pair_t HR_RESET    = to_bcd_pair(HR12_MAX);
  localparam bcd_pair_t HR_TOP_BCD  = to_bcd_pair(HR12_MAX);
  localparam bcd_pair_t HR_LOW_BCD  = to_bcd_pair(HR12_MIN);
  localparam bcd_pair_t HR_NOON_PRE = to_bcd_pair(HR12_MAX - 1);
`else
  localparam bcd_pair_t HR_RESET    = '0;
  localparam bcd_pair_t HR_TOP_BCD  = to_bcd_pair(HR24_MAX);
`endif

  logic [PRESC_W-1:0]      presc;
  logic                    advance;
  logic                    tick_q;
  bcd_pair_t               sec_q;
  bcd_pair_t               min_q;
  bcd_pair_t               hr_q;
  logic                    pm_q;
  logic [REFRESH_BITS-1:0] refresh_cnt;
  logic                    press_hr;
  logic                    press_min;
  logic                    sec_wrap;
  logic                    min_wrap;
  bcd_pair_t               sec_next;
  bcd_pair_t               min_next;
  bcd_pair_t               hr_next;
  logic                    pm_next;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_hr (
    .clk     (clk),
    .reset_n (reset_n),
    .btn     (btn_hr),
    .press   (press_hr)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_min (
    .clk     (clk),
    .reset_n (reset_n),
    .btn     (btn_min),
    .press   (press_min)
  );

  // Seconds and minutes share the same 00..59 wrap; both the carry path and
  // the minute button use min_next.
  always_comb begin
    sec_wrap = (sec_q == SEC_MAX_BCD);
    min_wrap = (min_q == MIN_MAX_BCD);
    sec_next = sec_wrap ? bcd_pair_t'('0) : bcd_pair_inc(sec_q);
    min_next = min_wrap ? bcd_pair_t'('0) : bcd_pair_inc(min_q);
  end

`ifdef CLOCK_12H_MODE_EN
  // 12 wraps to 01 without touching pm; pm flips only on 11 -> 12.
  always_comb begin
    hr_next = bcd_pair_inc(hr_q);
    pm_next = pm_q;
    if (hr_q == HR_TOP_BCD) begin
      hr_next = HR_LOW_BCD;
    end else if (hr_q == HR_NOON_PRE) begin
      pm_next = ~pm_q;
    end
  end
`else
  always_comb begin
    hr_next = (hr_q == HR_TOP_BCD) ? bcd_pair_t'('0) : bcd_pair_inc(hr_q);
    pm_next = 1'b0;
  end
`endif

  // The prescaler wrap is registered into 'advance' and applied one edge
  // later, so the digits and tick_1hz change together. A press pulse wins
  // over a pending advance (that second is dropped). The minute button also
  // restarts the prescaler and cancels an advance raised in the same edge,
  // so the new minute always starts a full second from :00.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc       <= '0;
      advance     <= 1'b0;
      tick_q      <= 1'b0;
      sec_q       <= '0;
      min_q       <= '0;
      hr_q        <= HR_RESET;
      pm_q        <= 1'b0;
      refresh_cnt <= '0;
    end else begin
      refresh_cnt <= refresh_cnt + REFRESH_BITS'(1);
      tick_q      <= 1'b0;
      advance     <= 1'b0;
      if (run_en) begin
        if (presc == PRESC_LAST) begin
          presc   <= '0;
          advance <= 1'b1;
        end else begin
          presc <= presc + PRESC_W'(1);
        end
      end
      if (press_min || press_hr) begin
        if (press_min) begin
          min_q   <= min_next;
          sec_q   <= '0;
          presc   <= '0;
          advance <= 1'b0;
        end
        if (press_hr) begin
          hr_q <= hr_next;
          pm_q <= pm_next;
        end
      end else if (advance) begin
        tick_q <= 1'b1;
        sec_q  <= sec_next;
        if (sec_wrap) begin
          min_q <= min_next;
          if (min_wrap) begin
            hr_q <= hr_next;
            pm_q <= pm_next;
          end
        end
      end
    end
  end

  assign sec_1s        = sec_q.ones;
  assign sec_10s       = sec_q.tens;
  assign min_1s        = min_q.ones;
  assign min_10s       = min_q.tens;
  assign hr_1s         = hr_q.ones;
  assign hr_10s        = hr_q.tens;
  assign pm            = pm_q;
  assign tick_1hz      = tick_q;
  assign refresh_digit = refresh_cnt[REFRESH_BITS-1 -: 2];

endmodule

// File: tb/tb_clock_time_core.sv
// tb_clock_time_core
// Directed bench for clock_time_core with a 10-cycle second and a 4-sample
// debouncer. A behavioural integer hh/mm/ss model produces expected digit
// snapshots, which are queued when stimulus is applied and popped when the
// DUT is sampled (on the falling edge). Builds in 24 h mode by default and
// switches to the 12 h checks when CLOCK_12H_MODE_EN is defined.
module tb_clock_time_core;

  localparam int CLK_HZ = 10;
  localparam int DEB    = 4;
  localparam int RB     = 4;

  logic       clk;
  logic       reset_n;
  logic       run_en;
  logic       btn_hr;
  logic       btn_min;
  logic [3:0] sec_1s, sec_10s, min_1s, min_10s, hr_1s, hr_10s;
  logic       pm;
  logic       tick_1hz;
  logic [1:0] refresh_digit;

  clock_time_core #(
    .CLK_HZ          (CLK_HZ),
    .DEBOUNCE_CYCLES (DEB),
    .REFRESH_BITS    (RB)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .run_en        (run_en),
    .btn_hr        (btn_hr),
    .btn_min       (btn_min),
    .sec_1s        (sec_1s),
    .sec_10s       (sec_10s),
    .min_1s        (min_1s),
    .min_10s       (min_10s),
    .hr_1s         (hr_1s),
    .hr_10s        (hr_10s),
    .pm            (pm),
    .tick_1hz      (tick_1hz),
    .refresh_digit (refresh_digit)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [3:0] h10, h1, m10, m1, s10, s1;
    logic       pm;
  } snap_t;

  snap_t exp_q[$];
  int    n_compared    = 0;
  int    n_mismatched  = 0;
  int    illegal_count = 0;
  int    hh, mm, ss;
  logic  mpm;

  // Digit range watchdog over the whole run.
  function automatic bit digits_legal();
    int h;
    h = int'(hr_10s) * 10 + int'(hr_1s);
    if (sec_1s > 4'd9 || sec_10s > 4'd5 || min_1s > 4'd9 || min_10s > 4'd5 || hr_1s > 4'd9)
      return 1'b0;
`ifdef CLOCK_12H_MODE_EN
    return (h >= 1 && h <= 12);
`else
    return (h <= 23);
`endif
  endfunction

  always @(negedge clk) begin
    if (reset_n === 1'b1 && !digits_legal()) illegal_count++;
  end

  function automatic snap_t model_snap();
    snap_t s;
    s.h10 = 4'(hh / 10);
    s.h1  = 4'(hh % 10);
    s.m10 = 4'(mm / 10);
    s.m1  = 4'(mm % 10);
    s.s10 = 4'(ss / 10);
    s.s1  = 4'(ss % 10);
    s.pm  = mpm;
    return s;
  endfunction

  function automatic snap_t dut_snap();
    snap_t s;
    s.h10 = hr_10s;
    s.h1  = hr_1s;
    s.m10 = min_10s;
    s.m1  = min_1s;
    s.s10 = sec_10s;
    s.s1  = sec_1s;
    s.pm  = pm;
    return s;
  endfunction

  task automatic model_reset();
`ifdef CLOCK_12H_MODE_EN
    hh = 12;
`else
    hh = 0;
`endif
    mm  = 0;
    ss  = 0;
    mpm = 1'b0;
  endtask

  task automatic model_hr_step();
`ifdef CLOCK_12H_MODE_EN
    if (hh == 12) hh = 1;
    else begin
      if (hh == 11) mpm = ~mpm;
      hh = hh + 1;
    end
`else
    hh = (hh + 1) % 24;
`endif
  endtask

  task automatic model_tick();
    ss = ss + 1;
    if (ss == 60) begin
      ss = 0;
      mm = mm + 1;
      if (mm == 60) begin
        mm = 0;
        model_hr_step();
      end
    end
  endtask

  task automatic model_min_press();
    mm = (mm + 1) % 60;
    ss = 0;
  endtask

  task automatic push_expected();
    exp_q.push_back(model_snap());
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_compared++;
    assert (obs === expv) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_output(input string tag);
    snap_t o, e;
    o = dut_snap();
    n_compared++;
    if (exp_q.size() == 0) begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %h, expected entry missing from queue", tag, o);
    end else begin
      e = exp_q.pop_front();
      assert (o === e) else begin
        n_mismatched++;
        $error("[TB] FAIL %s: observed %h%h:%h%h:%h%h pm=%b expected %h%h:%h%h:%h%h pm=%b",
               tag, o.h10, o.h1, o.m10, o.m1, o.s10, o.s1, o.pm,
               e.h10, e.h1, e.m10, e.m1, e.s10, e.s1, e.pm);
      end
    end
  endtask

  // Holds reset for three edges, checks the reset state, then releases.
  // Returns at the falling edge right after the last reset edge.
  task automatic do_reset();
    reset_n = 1'b0;
    run_en  = 1'b0;
    btn_hr  = 1'b0;
    btn_min = 1'b0;
    model_reset();
    push_expected();
    repeat (3) @(negedge clk);
    check_output("reset_digits");
    check_val("reset_tick", tick_1hz, 0);
    check_val("reset_refresh", refresh_digit, 0);
    reset_n = 1'b1;
  endtask

  task automatic wait_tick(input int budget, input string tag, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (tick_1hz !== 1'b1 && waited < budget);
    check_val({tag, "_seen"}, tick_1hz, 1);
  endtask

  task automatic tick_and_check(input string tag, input int budget, input int exp_wait);
    int w;
    model_tick();
    push_expected();
    wait_tick(budget, tag, w);
    if (exp_wait >= 0) check_val({tag, "_period"}, w, exp_wait);
    check_output(tag);
  endtask

  // Raw button high for 6 cycles. Raised before edge k, the digits must still
  // be old after edge k+6 and new after edge k+7 (2 sync + 4 debounce +
  // 1 edge detect + 1 update).
  task automatic press_timed(input bit use_hr, input int tail, input string tag);
    push_expected();
    if (use_hr) model_hr_step();
    else model_min_press();
    push_expected();
    if (use_hr) btn_hr = 1'b1;
    else btn_min = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 6) begin
        btn_hr  = 1'b0;
        btn_min = 1'b0;
      end
      if (i == 7) check_output({tag, "_before"});
      if (i == 8) check_output({tag, "_after"});
    end
    repeat (tail) @(negedge clk);
  endtask

  task automatic press_n(input bit use_hr, input int n);
    for (int i = 0; i < n; i++) press_timed(use_hr, 6, use_hr ? "preset_hr" : "preset_min");
  endtask

  task automatic run_ticks(input int n);
    run_en = 1'b1;
    for (int i = 0; i < n; i++) tick_and_check("preset_tick", 12, -1);
  endtask

  task automatic preset(input int n_hr, input int n_min, input int n_ticks);
    do_reset();
    press_n(1'b1, n_hr);
    press_n(1'b0, n_min);
    run_ticks(n_ticks);
  endtask

  initial begin
    int stray;
    reset_n = 1'b0;
    run_en  = 1'b0;
    btn_hr  = 1'b0;
    btn_min = 1'b0;

    // Reset release with run_en high: the first tick lands 11 edges after
    // the last reset edge (10 counts plus the registered advance stage).
    do_reset();
    run_en = 1'b1;
    model_tick();
    push_expected();
    stray = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k % 4 == 1 || k == 16) check_val($sformatf("refresh_k%0d", k), refresh_digit, (k % 16) / 4);
      if (k == 11) check_output("first_tick");
      else if (tick_1hz !== 1'b0) stray++;
    end
    check_val("no_early_tick", stray, 0);
    tick_and_check("tick2", 20, 5);
    @(negedge clk);
    check_val("tick_width", tick_1hz, 0);
    tick_and_check("tick3", 20, 9);

    // Freeze: no ticks, digits held, then resume from the held count.
    run_en = 1'b0;
    push_expected();
    stray = 0;
    repeat (30) begin
      @(negedge clk);
      if (tick_1hz !== 1'b0) stray++;
    end
    check_val("hold_no_tick", stray, 0);
    check_output("hold_digits");
    run_en = 1'b1;
    tick_and_check("resume", 20, 10);

    // Debounce behaviour with time frozen.
    run_en = 1'b0;
    push_expected();
    btn_min = 1'b1;
    repeat (3) @(negedge clk);
    btn_min = 1'b0;
    repeat (12) @(negedge clk);
    check_output("short_press_ignored");
    press_timed(1'b0, 6, "min_press");
    model_min_press();
    push_expected();
    for (int j = 0; j < 10; j++) begin
      btn_min = (j % 2 == 0);
      @(negedge clk);
    end
    btn_min = 1'b1;
    repeat (8) @(negedge clk);
    btn_min = 1'b0;
    repeat (12) @(negedge clk);
    check_output("bounce_single_press");

    // Hour press pulse lands in the same cycle as a pending advance.
    run_en = 1'b1;
    tick_and_check("realign", 14, 11);
    repeat (2) @(negedge clk);
    press_timed(1'b1, 0, "collide");
    check_val("collide_no_tick", tick_1hz, 0);
    tick_and_check("after_collide", 14, 10);

`ifdef CLOCK_12H_MODE_EN
    preset(11, 59, 59);
    tick_and_check("to_noon", 12, 10);
    run_en = 1'b0;
    press_n(1'b0, 59);
    run_ticks(59);
    tick_and_check("to_one", 12, 10);
    run_en = 1'b0;
    press_n(1'b1, 11);
`else
    preset(23, 59, 59);
    tick_and_check("wrap_midnight", 12, 10);

    // Minute press restarts the second: 12:59:37 -> 12:00:00, then a full
    // prescaler period plus the advance stage (same as after reset) to 12:00:01.
    preset(12, 59, 37);
    press_timed(1'b0, 0, "min_at_125937");
    tick_and_check("after_min_press", 15, 11);
`endif

    check_val("illegal_digits", illegal_count, 0);
    check_val("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed run still active, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
